fire_sensor_conditioner: RTL and testbench
==========================================

Name: fire_sensor_conditioner

Overview:
Conditions the raw active-low fire sensor line before it drives the motor controller's fire_in input. Synchronises the pin, debounces fire assertion and latches a confirmed fire until the sensor has been clear for a set time and an operator acknowledge arrives. Exports a fail-safe, active-low fire_out (1 = safe to run), an alarm flag and a saturating fire-event counter for the monitoring logic.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synced low samples needed to confirm a fire (>=1)
CLEAR_CYCLES, 32, consecutive synced high samples needed before running is allowed (>=1)
CNT_W, 8, width of fire_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
fire_raw  input  1  raw sensor pin, active-low (0 = fire), asynchronous to clk
ack  input  1  operator acknowledge, synchronous, sampled each cycle
fire_out  output  1  to motor fire_in; 1 = no fire/run allowed, 0 = stop
alarm  output  1  1 while a confirmed fire is latched
fire_count  output  CNT_W  number of confirmed fire events, saturating
state_dbg  output  2  current state encoding

Behaviour:
- Synchroniser: 2 flops on fire_raw; both reset to 0 (fail-safe = fire). s = second flop output.
- One internal counter cnt, width $clog2(max(DEBOUNCE_CYCLES,CLEAR_CYCLES)+1), reset 0.
- States: STARTUP=2'd0, NORMAL=2'd1, FIRE=2'd2; 2'd3 unused and goes to STARTUP next edge.
- Moore outputs decoded from the state register: fire_out=1 only in NORMAL; alarm=1 only in FIRE; state_dbg=state.
- Reset (async, any time, including mid-FIRE): state=STARTUP, cnt=0, fire_count=0, sync flops=0. Outputs go immediately to fire_out=0, alarm=0, fire_count=0, state_dbg=0.
- STARTUP:
  - s==1 increments cnt; s==0 clears cnt.
  - When s==1 and cnt==CLEAR_CYCLES-1: go to NORMAL, cnt=0. ack is ignored.
- NORMAL:
  - s==0 increments cnt; s==1 clears cnt.
  - When s==0 and cnt==DEBOUNCE_CYCLES-1: go to FIRE, cnt=0, fire_count+1 (holds at all-ones).
  - Low glitches shorter than DEBOUNCE_CYCLES synced samples never trip.
- FIRE:
  - s==1 increments cnt, saturating at CLEAR_CYCLES; s==0 clears cnt.
  - When ack==1 and cnt==CLEAR_CYCLES and s==1: go to NORMAL, cnt=0.
  - ack under any other condition is dropped and not remembered. Re-trip is possible only after a return to NORMAL.
- Latency:
  - Count edges from the first rising edge after fire_raw changes (edge 0).
  - NORMAL->FIRE occurs at edge DEBOUNCE_CYCLES+1.
  - STARTUP->NORMAL with fire_raw held high from reset release occurs at edge CLEAR_CYCLES+1.
  - ack->NORMAL takes effect on the same edge ack is sampled.
- fire_count increments only on the NORMAL->FIRE transition. It never wraps.

Test Plan:
Use DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8, CNT_W=4.
1. Release rst with fire_raw=1 -> fire_out=0 through edge 8; fire_out=1, state_dbg=1 after edge 9 (edge 0 = first edge after release); alarm=0 throughout.
2. In NORMAL, fire_raw=0 for 3 clocks then 1 -> fire_out stays 1, alarm 0, fire_count 0; a 5-clock low pulse -> trip, fire_count=1.
3. In NORMAL, hold fire_raw=0 -> fire_out=0, alarm=1, state_dbg=2 after edge 5; fire_count=1.
4. In FIRE, pulse ack with fire_raw=0, then pulse ack after only 5 clear clocks -> both ignored, alarm stays 1. After fire_raw=1 for 12 clocks, pulse ack -> fire_out=1 and alarm=0 right after that edge.
5. Run 17 confirmed fire/ack cycles -> fire_count reads 15 after the 15th event and stays 15.
6. Assert rst asynchronously mid-FIRE (between edges) -> fire_out=0, alarm=0, fire_count=0, state_dbg=0 before the next edge. After release, the scenario 1 timing repeats.

Source files
------------

// File: rtl/fire_sensor_conditioner.sv
// Conditions the active-low fire sensor line: synchronise, debounce, latch confirmed
// fires until the line is clear and acknowledged; counts fire events (saturating).
module fire_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CLEAR_CYCLES    = 32,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire_raw,
    input  logic             ack,
    output logic             fire_out,
    output logic             alarm,
    output logic [CNT_W-1:0] fire_count,
    output logic [1:0]       state_dbg
);

    localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > CLEAR_CYCLES) ? DEBOUNCE_CYCLES : CLEAR_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] CLR_FULL = CW'(CLEAR_CYCLES);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_FIRE    = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fire_out_q, alarm_q;
    logic             s;

    assign s = sync2_q;

    // Next-state, run counter and event counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            ST_STARTUP: begin
                if (s) begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_NORMAL: begin
                if (!s) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_FIRE;
                        cnt_d   = '0;
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_FIRE: begin
                if (s) begin
                    if (ack && (cnt_q == CLR_FULL)) begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end else if (cnt_q != CLR_FULL) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Sync flops reset to 0 so an unknown line reads as fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_STARTUP;
            cnt_q      <= '0;
            count_q    <= '0;
            fire_out_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            sync1_q    <= fire_raw;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            fire_out_q <= (state_d == ST_NORMAL);
            alarm_q    <= (state_d == ST_FIRE);
        end
    end

    assign fire_out   = fire_out_q;
    assign alarm      = alarm_q;
    assign fire_count = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fire_sensor_conditioner.sv
// Bench for fire_sensor_conditioner: directed scenarios plus random line/ack activity,
// checked every cycle against a run-length reference model.
module tb_fire_sensor_conditioner;

    localparam int unsigned DEB   = 4;
    localparam int unsigned CLR   = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             fire_raw;
    logic             ack;
    logic             fire_out;
    logic             alarm;
    logic [CNT_W-1:0] fire_count;
    logic [1:0]       state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sync pipeline, mode, and lengths of the current high/low runs
    int m_r1, m_r2, m_mode, m_hi, m_lo, m_events;

    fire_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CLEAR_CYCLES   (CLR),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fire_raw  (fire_raw),
        .ack       (ack),
        .fire_out  (fire_out),
        .alarm     (alarm),
        .fire_count(fire_count),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_mode = 0; m_hi = 0; m_lo = 0; m_events = 0;
    endtask

    task automatic model_edge();
        int s;
        int next_mode;
        if (rst) return;
        s = m_r2;
        m_r2 = m_r1;
        m_r1 = int'(fire_raw);
        next_mode = m_mode;
        case (m_mode)
            0: begin
                m_hi = s ? m_hi + 1 : 0;
                if (m_hi == CLR) next_mode = 1;
            end
            1: begin
                m_lo = s ? 0 : m_lo + 1;
                if (m_lo == DEB) begin
                    next_mode = 2;
                    if (m_events < SAT) m_events++;
                end
            end
            default: begin
                if (s == 1 && ack && m_hi >= CLR) next_mode = 1;
                else m_hi = s ? m_hi + 1 : 0;
            end
        endcase
        if (next_mode != m_mode) begin
            m_hi = 0;
            m_lo = 0;
        end
        m_mode = next_mode;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".fire_out"}, 32'(fire_out), 32'(m_mode == 1));
        chk({tag, ".alarm"}, 32'(alarm), 32'(m_mode == 2));
        chk({tag, ".count"}, 32'(fire_count), 32'(m_events));
        chk({tag, ".state"}, 32'(state_dbg), 32'(m_mode));
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic ack_pulse(input string tag);
        ack = 1'b1;
        cycle(tag);
        ack = 1'b0;
    endtask

    task automatic startup_timing(input string tag);
        for (int e = 0; e <= 11; e++) begin
            cycle(tag);
            chk({tag, ".fo_edge"}, 32'(fire_out), 32'(e >= 9));
            chk({tag, ".alarm0"}, 32'(alarm), 32'd0);
        end
        chk({tag, ".state_normal"}, 32'(state_dbg), 32'd1);
    endtask

    initial begin
        rst = 1'b1; fire_raw = 1'b1; ack = 1'b0;
        model_reset();
        #12;
        chk("reset.fire_out", 32'(fire_out), 32'd0);
        chk("reset.state", 32'(state_dbg), 32'd0);
        chk("reset.count", 32'(fire_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: startup qualification
        startup_timing("s1");

        // 2: short glitch ignored, then a held low trips
        fire_raw = 1'b0; run(3, "s2.glitch");
        fire_raw = 1'b1; run(6, "s2.recover");
        chk("s2.no_trip_count", 32'(fire_count), 32'd0);
        chk("s2.no_trip_fo", 32'(fire_out), 32'd1);

        // 3: held low -> FIRE after edge 5
        fire_raw = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            cycle("s3");
            chk("s3.alarm_edge", 32'(alarm), 32'(e >= 5));
        end
        chk("s3.state", 32'(state_dbg), 32'd2);
        chk("s3.count", 32'(fire_count), 32'd1);

        // 4: early acks dropped, qualified ack releases
        ack_pulse("s4.ack_low");
        fire_raw = 1'b1; run(4, "s4.clear5");
        ack_pulse("s4.ack_early");
        chk("s4.still_alarm", 32'(alarm), 32'd1);
        run(6, "s4.clear12");
        ack_pulse("s4.ack_ok");
        chk("s4.released_fo", 32'(fire_out), 32'd1);
        chk("s4.released_alarm", 32'(alarm), 32'd0);

        // 5: counter saturates
        for (int k = 0; k < 17; k++) begin
            fire_raw = 1'b0; run(6, "s5.trip");
            fire_raw = 1'b1; run(10, "s5.clear");
            ack_pulse("s5.ack");
        end
        chk("s5.saturated", 32'(fire_count), 32'(SAT));

        // 6: async reset mid-FIRE
        fire_raw = 1'b0; run(7, "s6.trip");
        chk("s6.in_fire", 32'(state_dbg), 32'd2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("s6.rst_fo", 32'(fire_out), 32'd0);
        chk("s6.rst_alarm", 32'(alarm), 32'd0);
        chk("s6.rst_count", 32'(fire_count), 32'd0);
        chk("s6.rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        fire_raw = 1'b1;
        rst = 1'b0;
        startup_timing("s6.restart");

        // Random line segments with random acks
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            fire_raw = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            for (int i = 0; i < len; i++) begin
                ack = ($urandom_range(0, 3) == 0);
                cycle("rnd");
            end
        end
        ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
